mem_stage: RTL and testbench
============================

# mem_stage

Pipeline memory-access stage between the execute stage and write-back. It registers the execute-stage bus and takes the synchronous data-SRAM read data, whose address was issued one cycle earlier by the execute stage. It extracts and extends the addressed byte, halfword or word for loads, and forwards the write-back bus. A one-entry hold register preserves load data while write-back stalls, because a stall lets the execute stage overwrite the SRAM read port.

## Interface
- `ES_TO_MS_BUS_WD`, 74: input bus width. Fields:
  - [73:71] load_type
  - [70] res_from_mem
  - [69] gr_we
  - [68:64] dest
  - [63:32] alu_result
  - [31:0] pc
- `MS_TO_WS_BUS_WD`, 70: output bus width. Fields:
  - [69] gr_we
  - [68:64] dest
  - [63:32] final_result
  - [31:0] pc
- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; a 0 clears all state immediately.
- `ws_allowin` input 1: write-back can accept this cycle.
- `ms_allowin` output 1: this stage can accept this cycle.
- `es_to_ms_valid` input 1: execute stage presents a valid instruction.
- `es_to_ms_bus` input 74: execute-stage payload.
- `ms_to_ws_valid` output 1: valid instruction toward write-back.
- `ms_to_ws_bus` output 70: write-back payload.
- `data_sram_rdata` input 32: SRAM read data, valid in the first cycle an instruction occupies this stage.
- `ms_dest` output 5: destination register for bypass/interlock; 0 when invalid or gr_we=0.
- `ms_to_ds_result` output 32: final_result, for forwarding to decode.

## Operation
- State:
  - `ms_valid`
  - bus register (74 b)
  - `ms_first`: the instruction entered on the previous edge
  - `rdata_hold` (32 b)
- Handshake:
  - ms_ready_go=1.
  - ms_allowin = !ms_valid || ws_allowin.
  - ms_to_ws_valid = ms_valid.
- On an edge with ms_allowin=1:
  - ms_valid <= es_to_ms_valid.
  - If es_to_ms_valid=1: the bus register loads es_to_ms_bus and ms_first <= 1.
  - Otherwise ms_first <= 0.
- On an edge with ms_allowin=0: ms_first <= 0.
- Whenever ms_first=1: rdata_hold <= data_sram_rdata.
- raw_data = ms_first ? data_sram_rdata : rdata_hold.
- Load extraction uses a = alu_result[1:0]:
  - load_type 0 (lw): raw_data.
  - 1 (lb): sign-extend raw_data[8a+7:8a].
  - 2 (lbu): zero-extend that byte.
  - 3 (lh): sign-extend raw_data[31:16] if a[1], else raw_data[15:0].
  - 4 (lhu): zero-extend the same halfword.
  - 5–7: treated as lw.
  - Misaligned lh/lw: no exception. The address low bits are ignored beyond a[1] for halfword; lw ignores a entirely.
- final_result = res_from_mem ? extracted load data : alu_result.
- ms_to_ws_bus = {gr_we, dest, final_result, pc}.
- ms_dest = dest & {5{ms_valid & gr_we}}.
- ms_to_ds_result = final_result, combinational; only meaningful when ms_valid.

## Timing
- Async reset (reset=0) clears immediately:
  - ms_valid=0, ms_first=0, rdata_hold=0, bus register=0.
  - Resulting outputs: ms_to_ws_valid=0, ms_allowin=1, ms_dest=0, ms_to_ds_result=0, ms_to_ws_bus=0.
- Reset deassertion takes effect at the first rising edge after reset=1.
- Latency: an instruction accepted at edge N is visible on ms_to_ws_* during cycle N→N+1. It leaves at the first later edge with ws_allowin=1.
- Stall: with ws_allowin=0, the outputs are held stable every cycle, including the load result. The SRAM read data is used only in the first cycle (ms_first); every later stalled cycle uses rdata_hold, regardless of data_sram_rdata.
- Back-to-back: with ws_allowin=1 continuously, one instruction per cycle and ms_first=1 every cycle.
- Simultaneous leave and enter on the same edge: the new instruction replaces the old, and ms_first=1 for the new one.
- Bubble: es_to_ms_valid=0 while ms_allowin=1 gives ms_valid=0 next cycle; the bus register keeps its old value, and ms_dest is forced 0.
- Reset asserted mid-stall discards the held instruction. The first instruction after reset uses fresh SRAM data.

## Test plan
- Reset: hold reset=0 with random inputs.
  - Required: ms_to_ws_valid=0, ms_allowin=1, ms_dest=0, ms_to_ds_result=0.
  - Drive reset=0 asynchronously mid-cycle while valid: outputs clear before the next edge.
- Load extraction: rdata=0x8899_AABB, res_from_mem=1.
  - lb, a=0 → 0xFFFF_FFBB.
  - lbu, a=1 → 0x0000_00AA.
  - lh, a=2 → 0xFFFF_8899.
  - lhu, a=0 → 0x0000_AABB.
  - lw → 0x8899_AABB.
- Stall hold: lw enters with rdata=0x1234_5678, then ws_allowin=0 for 3 cycles while rdata changes to 0xDEAD_BEEF.
  - Required: final_result=0x1234_5678 on every stalled cycle.
  - Required: ms_allowin=0 while stalled; the instruction leaves on the edge when ws_allowin=1.
- Non-load path: res_from_mem=0, alu_result=0x0000_0040, dest=5, gr_we=1.
  - Required: final_result=0x40, ms_dest=5.
  - With gr_we=0: ms_dest=0.
- Throughput/bubbles: 4 back-to-back instructions with ws_allowin=1 → 4 consecutive valid cycles with in-order pc.
  - Insert a bubble (es_to_ms_valid=0) → one cycle with ms_to_ws_valid=0 and ms_dest=0.
- Reset mid-stall: a load is stalled, then reset pulses to 0 → valid=0.
  - The next load after reset takes its data from data_sram_rdata, not from the stale hold value.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus, extracts load data from the
// synchronous SRAM read port, and holds that data across write-back stalls.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 74,
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic [4:0]                 ms_dest,
  output logic [31:0]                ms_to_ds_result
);

  logic                       r_ms_valid;
  logic                       r_ms_first;
  logic [ES_TO_MS_BUS_WD-1:0] r_bus;
  logic [31:0]                r_rdata_hold;

  logic        w_ms_allowin;
  logic [2:0]  w_load_type;
  logic        w_res_from_mem;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_alu_result;
  logic [31:0] w_pc;
  logic [31:0] w_raw_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_final_result;

  assign w_ms_allowin   = !r_ms_valid || ws_allowin;

  assign w_load_type    = r_bus[73:71];
  assign w_res_from_mem = r_bus[70];
  assign w_gr_we        = r_bus[69];
  assign w_dest         = r_bus[68:64];
  assign w_alu_result   = r_bus[63:32];
  assign w_pc           = r_bus[31:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ms_valid   <= 1'b0;
      r_ms_first   <= 1'b0;
      r_bus        <= '0;
      r_rdata_hold <= '0;
    end else begin
      if (w_ms_allowin) begin
        r_ms_valid <= es_to_ms_valid;
        r_ms_first <= es_to_ms_valid;
        if (es_to_ms_valid) begin
          r_bus <= es_to_ms_bus;
        end
      end else begin
        r_ms_first <= 1'b0;
      end
      // The SRAM port is only ours in the first cycle; capture it before execute reuses it.
      if (r_ms_first) begin
        r_rdata_hold <= data_sram_rdata;
      end
    end
  end

  assign w_raw_data = r_ms_first ? data_sram_rdata : r_rdata_hold;

  always_comb begin
    w_byte = w_raw_data[7:0];
    case (w_alu_result[1:0])
      2'd1:    w_byte = w_raw_data[15:8];
      2'd2:    w_byte = w_raw_data[23:16];
      2'd3:    w_byte = w_raw_data[31:24];
      default: w_byte = w_raw_data[7:0];
    endcase
    // Halfword alignment looks only at a[1]; a misaligned lh is not trapped here.
    w_half = w_alu_result[1] ? w_raw_data[31:16] : w_raw_data[15:0];

    w_load_data = w_raw_data;
    case (w_load_type)
      3'd1:    w_load_data = {{24{w_byte[7]}}, w_byte};
      3'd2:    w_load_data = {24'd0, w_byte};
      3'd3:    w_load_data = {{16{w_half[15]}}, w_half};
      3'd4:    w_load_data = {16'd0, w_half};
      default: w_load_data = w_raw_data;
    endcase
  end

  assign w_final_result = w_res_from_mem ? w_load_data : w_alu_result;

  assign ms_allowin      = w_ms_allowin;
  assign ms_to_ws_valid  = r_ms_valid;
  assign ms_to_ws_bus    = {w_gr_we, w_dest, w_final_result, w_pc};
  assign ms_dest         = w_dest & {5{r_ms_valid & w_gr_we}};
  assign ms_to_ds_result = w_final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, load extraction, stall hold, bypass outputs,
// throughput/bubbles and reset during a stall, all with hand-computed expectations.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [31:0] data_sram_rdata;
  logic [4:0]  ms_dest;
  logic [31:0] ms_to_ds_result;

  int n_total = 0;
  int n_pass  = 0;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_dest         (ms_dest),
    .ms_to_ds_result (ms_to_ds_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  function automatic logic [73:0] mk_bus(input logic [2:0] lt, input logic rfm,
                                         input logic we, input logic [4:0] dest,
                                         input logic [31:0] alu, input logic [31:0] pc);
    return {lt, rfm, we, dest, alu, pc};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset           = 1'b0;
    ws_allowin      = $urandom();
    es_to_ms_valid  = $urandom();
    es_to_ms_bus    = {$urandom(), $urandom(), $urandom()};
    data_sram_rdata = $urandom();

    // Reset held with random inputs toggling across edges
    tick();
    es_to_ms_valid  = 1'b1;
    es_to_ms_bus    = {$urandom(), $urandom(), $urandom()};
    data_sram_rdata = $urandom();
    tick();
    chk("rst_valid",   70'(ms_to_ws_valid),  70'd0);
    chk("rst_allowin", 70'(ms_allowin),      70'd1);
    chk("rst_dest",    70'(ms_dest),         70'd0);
    chk("rst_result",  70'(ms_to_ds_result), 70'd0);
    chk("rst_bus",     ms_to_ws_bus,         70'd0);

    #3 reset = 1'b1;
    ws_allowin      = 1'b1;
    es_to_ms_valid  = 1'b1;
    data_sram_rdata = 32'h8899_AABB;

    // Load extraction, back to back
    es_to_ms_bus = mk_bus(3'd1, 1'b1, 1'b1, 5'd3, 32'h1000_0000, 32'h0000_0010);
    tick();
    chk("lb_a0",  70'(ms_to_ds_result), 70'h0000_0000_FFFF_FFBB);
    chk("lb_valid", 70'(ms_to_ws_valid), 70'd1);
    chk("lb_dest",  70'(ms_dest),        70'd3);
    es_to_ms_bus = mk_bus(3'd2, 1'b1, 1'b1, 5'd3, 32'h1000_0001, 32'h0000_0014);
    tick();
    chk("lbu_a1", 70'(ms_to_ds_result), 70'h0000_00AA);
    es_to_ms_bus = mk_bus(3'd3, 1'b1, 1'b1, 5'd3, 32'h1000_0002, 32'h0000_0018);
    tick();
    chk("lh_a2",  70'(ms_to_ds_result), 70'hFFFF_8899);
    es_to_ms_bus = mk_bus(3'd4, 1'b1, 1'b1, 5'd3, 32'h1000_0000, 32'h0000_001C);
    tick();
    chk("lhu_a0", 70'(ms_to_ds_result), 70'h0000_AABB);
    es_to_ms_bus = mk_bus(3'd0, 1'b1, 1'b1, 5'd3, 32'h1000_0002, 32'h0000_0020);
    tick();
    chk("lw_a2",  70'(ms_to_ds_result), 70'h8899_AABB);
    es_to_ms_bus = mk_bus(3'd1, 1'b1, 1'b1, 5'd3, 32'h1000_0003, 32'h0000_0024);
    tick();
    chk("lb_a3",  70'(ms_to_ds_result), 70'hFFFF_FF88);
    es_to_ms_bus = mk_bus(3'd3, 1'b1, 1'b1, 5'd3, 32'h1000_0003, 32'h0000_0028);
    tick();
    chk("lh_a3",  70'(ms_to_ds_result), 70'hFFFF_8899);
    es_to_ms_bus = mk_bus(3'd2, 1'b1, 1'b1, 5'd3, 32'h1000_0002, 32'h0000_002C);
    tick();
    chk("lbu_a2", 70'(ms_to_ds_result), 70'h0000_0099);
    es_to_ms_bus = mk_bus(3'd6, 1'b1, 1'b1, 5'd3, 32'h1000_0001, 32'h0000_0030);
    tick();
    chk("lt6_lw", 70'(ms_to_ds_result), 70'h8899_AABB);

    // Non-load path
    es_to_ms_bus = mk_bus(3'd1, 1'b0, 1'b1, 5'd5, 32'h0000_0040, 32'h0000_0034);
    tick();
    chk("alu_result", 70'(ms_to_ds_result), 70'h40);
    chk("alu_dest",   70'(ms_dest),         70'd5);
    chk("alu_bus",    ms_to_ws_bus, {1'b1, 5'd5, 32'h0000_0040, 32'h0000_0034});
    es_to_ms_bus = mk_bus(3'd0, 1'b0, 1'b0, 5'd5, 32'h0000_0040, 32'h0000_0038);
    tick();
    chk("nowe_dest",  70'(ms_dest),         70'd0);
    chk("nowe_bus",   ms_to_ws_bus, {1'b0, 5'd5, 32'h0000_0040, 32'h0000_0038});

    // Stall hold
    data_sram_rdata = 32'h1234_5678;
    es_to_ms_bus = mk_bus(3'd0, 1'b1, 1'b1, 5'd7, 32'h2000_0000, 32'h0000_0100);
    tick();
    ws_allowin   = 1'b0;
    es_to_ms_bus = mk_bus(3'd0, 1'b1, 1'b1, 5'd8, 32'h2000_0004, 32'h0000_0104);
    #1;
    chk("stall0_result",  70'(ms_to_ds_result), 70'h1234_5678);
    chk("stall0_allowin", 70'(ms_allowin),      70'd0);
    tick();
    data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("stall1_result",  70'(ms_to_ds_result), 70'h1234_5678);
    chk("stall1_allowin", 70'(ms_allowin),      70'd0);
    chk("stall1_bus", ms_to_ws_bus, {1'b1, 5'd7, 32'h1234_5678, 32'h0000_0100});
    tick();
    chk("stall2_result",  70'(ms_to_ds_result), 70'h1234_5678);
    chk("stall2_valid",   70'(ms_to_ws_valid),  70'd1);
    ws_allowin = 1'b1;
    #1;
    chk("unstall_allowin", 70'(ms_allowin),     70'd1);
    chk("unstall_result",  70'(ms_to_ds_result), 70'h1234_5678);
    tick();
    chk("after_stall_bus", ms_to_ws_bus, {1'b1, 5'd8, 32'hDEAD_BEEF, 32'h0000_0104});

    // Throughput then bubble
    for (int i = 0; i < 4; i++) begin
      es_to_ms_bus = mk_bus(3'd0, 1'b0, 1'b1, 5'(10 + i), 32'(32'hA0 + i), 32'(32'h200 + 4 * i));
      tick();
      chk("tput_valid", 70'(ms_to_ws_valid), 70'd1);
      chk("tput_pc",    70'(ms_to_ws_bus[31:0]), 70'(32'h200 + 4 * i));
      chk("tput_dest",  70'(ms_dest), 70'(10 + i));
    end
    es_to_ms_valid = 1'b0;
    es_to_ms_bus   = mk_bus(3'd0, 1'b0, 1'b1, 5'd20, 32'hFFFF_0000, 32'h0000_0300);
    tick();
    chk("bubble_valid", 70'(ms_to_ws_valid), 70'd0);
    chk("bubble_dest",  70'(ms_dest),        70'd0);
    chk("bubble_keep",  70'(ms_to_ds_result), 70'hA3);

    // Async reset mid-cycle while valid
    es_to_ms_valid  = 1'b1;
    data_sram_rdata = 32'h5555_AAAA;
    es_to_ms_bus    = mk_bus(3'd0, 1'b1, 1'b1, 5'd9, 32'h3000_0000, 32'h0000_0400);
    tick();
    chk("pre_arst_valid", 70'(ms_to_ws_valid), 70'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid",  70'(ms_to_ws_valid), 70'd0);
    chk("arst_bus",    ms_to_ws_bus,        70'd0);
    chk("arst_dest",   70'(ms_dest),        70'd0);
    #2 reset = 1'b1;

    // Reset in the middle of a stall, then a fresh load
    data_sram_rdata = 32'hCAFE_F00D;
    es_to_ms_bus    = mk_bus(3'd0, 1'b1, 1'b1, 5'd11, 32'h4000_0000, 32'h0000_0500);
    tick();
    ws_allowin = 1'b0;
    tick();
    data_sram_rdata = 32'h0000_0000;
    #1;
    chk("mstall_result", 70'(ms_to_ds_result), 70'hCAFE_F00D);
    #2 reset = 1'b0;
    #1;
    chk("mstall_rst_valid", 70'(ms_to_ws_valid), 70'd0);
    #2 reset = 1'b1;
    ws_allowin      = 1'b1;
    data_sram_rdata = 32'h0BAD_C0DE;
    es_to_ms_bus    = mk_bus(3'd0, 1'b1, 1'b1, 5'd12, 32'h4000_0004, 32'h0000_0504);
    tick();
    chk("post_rst_load", ms_to_ws_bus, {1'b1, 5'd12, 32'h0BAD_C0DE, 32'h0000_0504});
    es_to_ms_valid  = 1'b0;
    ws_allowin      = 1'b0;
    tick();
    data_sram_rdata = 32'h7777_7777;
    #1;
    chk("post_rst_hold", 70'(ms_to_ds_result), 70'h0BAD_C0DE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
